// File: rtl/snax_csr_req_buffer.sv
// snax_csr_req_buffer
// Decoupling buffer on the simplified CSR channel. Requests are queued in an
// in-order FIFO. Reads issue downstream only when the response FIFO has a slot
// reserved for their data, so the downstream response path never stalls.
// idle_o reports that nothing is queued, in flight, or waiting upstream.

module snax_csr_req_buffer #(
  parameter int unsigned ReqDepth = 4,
  parameter int unsigned RspDepth = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic [31:0] up_req_data_i,
  input  logic [31:0] up_req_addr_i,
  input  logic        up_req_write_i,
  input  logic        up_req_valid_i,
  output logic        up_req_ready_o,

  output logic [31:0] up_rsp_data_o,
  output logic        up_rsp_valid_o,
  input  logic        up_rsp_ready_i,

  output logic [31:0] dn_req_data_o,
  output logic [31:0] dn_req_addr_o,
  output logic        dn_req_write_o,
  output logic        dn_req_valid_o,
  input  logic        dn_req_ready_i,

  input  logic [31:0] dn_rsp_data_i,
  input  logic        dn_rsp_valid_i,
  output logic        dn_rsp_ready_o,

  output logic        idle_o,
  output logic        stray_rsp_o
);

  localparam int unsigned ReqAw = $clog2(ReqDepth);
  localparam int unsigned ReqPw = ReqAw + 1;
  localparam int unsigned RspAw = $clog2(RspDepth);
  localparam int unsigned RspPw = RspAw + 1;
  localparam int unsigned RspIw = (RspAw > 0) ? RspAw : 1;
  localparam int unsigned OutW  = RspAw + 1;

  // Pointers differ only in the wrap bit exactly when the FIFO is full.
  localparam logic [ReqPw-1:0] ReqFullXor = ReqPw'(ReqDepth);
  localparam logic [RspPw-1:0] RspFullXor = RspPw'(RspDepth);
  localparam logic [OutW:0]    CreditMax  = (OutW + 1)'(RspDepth);

  // ---------------------------------------------------------------------------
  // Request FIFO state
  // ---------------------------------------------------------------------------
  logic [31:0]      req_data_q  [ReqDepth];
  logic [31:0]      req_addr_q  [ReqDepth];
  logic             req_write_q [ReqDepth];
  logic [ReqPw-1:0] req_wr_ptr_q;
  logic [ReqPw-1:0] req_rd_ptr_q;
  logic [ReqAw-1:0] req_wr_idx;
  logic [ReqAw-1:0] req_rd_idx;
  logic             req_empty;
  logic             req_full;
  logic             req_push;
  logic             req_pop;
  logic             head_write;

  // ---------------------------------------------------------------------------
  // Response FIFO and credit state
  // ---------------------------------------------------------------------------
  logic [31:0]      rsp_data_q [RspDepth];
  logic [RspPw-1:0] rsp_wr_ptr_q;
  logic [RspPw-1:0] rsp_rd_ptr_q;
  logic [RspIw-1:0] rsp_wr_idx;
  logic [RspIw-1:0] rsp_rd_idx;
  logic [RspPw-1:0] rsp_count;
  logic             rsp_empty;
  logic             rsp_full;
  logic             rsp_push;
  logic             rsp_pop;

  logic [OutW-1:0]  outstanding_q;
  logic [OutW:0]    credit_sum;
  logic             read_credit_ok;
  logic             read_issue;
  logic             no_outstanding;

  assign req_wr_idx = req_wr_ptr_q[ReqAw-1:0];
  assign req_rd_idx = req_rd_ptr_q[ReqAw-1:0];
  assign req_empty  = (req_wr_ptr_q == req_rd_ptr_q);
  assign req_full   = ((req_wr_ptr_q ^ req_rd_ptr_q) == ReqFullXor);

  // A single-entry response FIFO has no index bits; its only slot is 0.
  if (RspAw == 0) begin : g_rsp_idx_single
    assign rsp_wr_idx = '0;
    assign rsp_rd_idx = '0;
  end else begin : g_rsp_idx_multi
    assign rsp_wr_idx = rsp_wr_ptr_q[RspIw-1:0];
    assign rsp_rd_idx = rsp_rd_ptr_q[RspIw-1:0];
  end

  assign rsp_empty = (rsp_wr_ptr_q == rsp_rd_ptr_q);
  assign rsp_full  = ((rsp_wr_ptr_q ^ rsp_rd_ptr_q) == RspFullXor);
  assign rsp_count = rsp_wr_ptr_q - rsp_rd_ptr_q;

  // Reads in flight plus responses still buffered must fit the response FIFO.
  // This sum only grows when a read is accepted downstream, so once the gate
  // opens for the head it stays open until that head is taken.
  assign credit_sum     = {1'b0, outstanding_q} + (OutW + 1)'(rsp_count);
  assign read_credit_ok = (credit_sum < CreditMax);
  assign no_outstanding = (outstanding_q == '0);

  assign head_write     = req_write_q[req_rd_idx];

  assign up_req_ready_o = !req_full;
  assign dn_req_valid_o = !req_empty && (head_write || read_credit_ok);
  assign dn_req_data_o  = req_empty ? 32'h0 : req_data_q[req_rd_idx];
  assign dn_req_addr_o  = req_empty ? 32'h0 : req_addr_q[req_rd_idx];
  assign dn_req_write_o = req_empty ? 1'b0  : head_write;

  assign up_rsp_valid_o = !rsp_empty;
  assign up_rsp_data_o  = rsp_empty ? 32'h0 : rsp_data_q[rsp_rd_idx];

  assign dn_rsp_ready_o = rst_ni;
  assign stray_rsp_o    = rst_ni && dn_rsp_valid_i && no_outstanding;

  assign req_push   = up_req_valid_i && up_req_ready_o;
  assign req_pop    = dn_req_valid_o && dn_req_ready_i;
  assign read_issue = req_pop && !head_write;
  assign rsp_push   = dn_rsp_valid_i && !no_outstanding;
  assign rsp_pop    = up_rsp_valid_o && up_rsp_ready_i;

  assign idle_o = req_empty && no_outstanding && rsp_empty;

  // Request FIFO pointers; reset flushes any queued requests.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_wr_ptr_q <= '0;
      req_rd_ptr_q <= '0;
    end else begin
      if (req_push) req_wr_ptr_q <= req_wr_ptr_q + ReqPw'(1);
      if (req_pop)  req_rd_ptr_q <= req_rd_ptr_q + ReqPw'(1);
    end
  end

  // Request storage; contents are only observed through valid pointers.
  always_ff @(posedge clk_i) begin
    if (req_push) begin
      req_data_q[req_wr_idx]  <= up_req_data_i;
      req_addr_q[req_wr_idx]  <= up_req_addr_i;
      req_write_q[req_wr_idx] <= up_req_write_i;
    end
  end

  // Count reads issued downstream whose response has not yet come back.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else begin
      unique case ({read_issue, rsp_push})
        2'b10:   outstanding_q <= outstanding_q + OutW'(1);
        2'b01:   outstanding_q <= outstanding_q - OutW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Response FIFO pointers; stray responses never touch them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_wr_ptr_q <= '0;
      rsp_rd_ptr_q <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr_q <= rsp_wr_ptr_q + RspPw'(1);
      if (rsp_pop)  rsp_rd_ptr_q <= rsp_rd_ptr_q + RspPw'(1);
    end
  end

  // Response storage.
  always_ff @(posedge clk_i) begin
    if (rsp_push) rsp_data_q[rsp_wr_idx] <= dn_rsp_data_i;
  end

  // Reservation must make response overflow impossible.
  a_rsp_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_push |-> !rsp_full);

  // Credits never exceed response capacity.
  a_credit_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    credit_sum <= CreditMax);

  // A presented downstream request holds until it is taken.
  a_dn_req_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
    dn_req_valid_o && !dn_req_ready_i |=> dn_req_valid_o && $stable(dn_req_addr_o)
                                         && $stable(dn_req_data_o) && $stable(dn_req_write_o));

endmodule
